serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 111 +++++++++++
 tb/tb_serial_add_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving an external 1-bit full adder, LSB first.
// One operation takes WIDTH RUN cycles plus one DONE cycle.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             fa_x,
   output logic             fa_y,
   output logic             fa_cin,
   input  logic             fa_z,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      fa_x    = 1'b0;
      fa_y    = 1'b0;
      fa_cin  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               a_d     = a;
               // Subtraction as A + ~B + 1: invert B and seed the carry.
               b_d     = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            fa_x    = a_q[0];
            fa_y    = b_q[0];
            fa_cin  = carry_q;
            res_d   = {fa_z, res_q[WIDTH-1:1]};
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Carry into MSB differing from carry out of MSB means signed overflow.
               ovf_d   = carry_q ^ fa_cout;
               cout_d  = fa_cout;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign result    = res_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a behavioural 1-bit full adder in the loop.
module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       start, sub;
   logic [7:0] a, b;
   logic       fa_x, fa_y, fa_cin, fa_z, fa_cout;
   logic       busy, done, carry_out, overflow;
   logic [7:0] result;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   always #5 clk = ~clk;

   assign fa_z    = fa_x ^ fa_y ^ fa_cin;
   assign fa_cout = (fa_x & fa_y) | (fa_x & fa_cin) | (fa_y & fa_cin);

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .fa_x(fa_x), .fa_y(fa_y), .fa_cin(fa_cin), .fa_z(fa_z), .fa_cout(fa_cout),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out), .overflow(overflow)
   );

   // Drives one operation and returns outputs at the first done; lat = edges after the start edge (-1 on timeout).
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic ts,
                         output logic [7:0] r, output logic c, output logic o, output int lat);
      @(negedge clk);
      a = ta; b = tb_; sub = ts; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      r = result; c = carry_out; o = overflow;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      tot_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); else pass_cnt++;
      tot_cnt++; if (result !== 8'd0) $display("FAIL reset_result got=%0d exp=0", result); else pass_cnt++;
      tot_cnt++; if ({carry_out, overflow} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {carry_out, overflow}); else pass_cnt++;
      tot_cnt++; if ({fa_x, fa_y, fa_cin} !== 3'b000) $display("FAIL reset_fa got=%b exp=000", {fa_x, fa_y, fa_cin}); else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      tot_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else pass_cnt++;
   endtask

   task automatic test_add();
      logic [7:0] r; logic c, o; int lat;
      run_op(8'd100, 8'd27, 1'b0, r, c, o, lat);
      tot_cnt++; if (lat !== 8) $display("FAIL add_latency got=%0d exp=8", lat); else pass_cnt++;
      tot_cnt++; if (r !== 8'd127) $display("FAIL add_100_27 got=%0d exp=127", r); else pass_cnt++;
      tot_cnt++; if ({c, o} !== 2'b00) $display("FAIL add_100_27_flags got=%b exp=00", {c, o}); else pass_cnt++;
      @(negedge clk);
      tot_cnt++; if ({busy, done} !== 2'b00) $display("FAIL add_after_done got=%b exp=00", {busy, done}); else pass_cnt++;
      tot_cnt++; if (result !== 8'd127) $display("FAIL add_result_held got=%0d exp=127", result); else pass_cnt++;
      run_op(8'd200, 8'd100, 1'b0, r, c, o, lat);
      tot_cnt++; if (r !== 8'd44) $display("FAIL add_200_100 got=%0d exp=44", r); else pass_cnt++;
      tot_cnt++; if ({c, o} !== 2'b10) $display("FAIL add_200_100_flags got=%b exp=10", {c, o}); else pass_cnt++;
   endtask

   task automatic test_sub();
      logic [7:0] r; logic c, o; int lat;
      run_op(8'd5, 8'd7, 1'b1, r, c, o, lat);
      tot_cnt++; if (r !== 8'hFE) $display("FAIL sub_5_7 got=%0d exp=254", r); else pass_cnt++;
      tot_cnt++; if ({c, o} !== 2'b00) $display("FAIL sub_5_7_flags got=%b exp=00", {c, o}); else pass_cnt++;
      run_op(8'd7, 8'd5, 1'b1, r, c, o, lat);
      tot_cnt++; if (r !== 8'd2) $display("FAIL sub_7_5 got=%0d exp=2", r); else pass_cnt++;
      tot_cnt++; if ({c, o} !== 2'b10) $display("FAIL sub_7_5_flags got=%b exp=10", {c, o}); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [7:0] r; logic c, o; int lat;
      run_op(8'd127, 8'd1, 1'b0, r, c, o, lat);
      tot_cnt++; if (r !== 8'd128) $display("FAIL ovf_add got=%0d exp=128", r); else pass_cnt++;
      tot_cnt++; if ({c, o} !== 2'b01) $display("FAIL ovf_add_flags got=%b exp=01", {c, o}); else pass_cnt++;
      run_op(8'd128, 8'd1, 1'b1, r, c, o, lat);
      tot_cnt++; if (r !== 8'd127) $display("FAIL ovf_sub got=%0d exp=127", r); else pass_cnt++;
      tot_cnt++; if ({c, o} !== 2'b11) $display("FAIL ovf_sub_flags got=%b exp=11", {c, o}); else pass_cnt++;
   endtask

   task automatic test_ignore_start();
      int dones = 0;
      @(negedge clk);
      a = 8'd100; b = 8'd27; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      // First bit of 100+27: x=0, y=1, cin=0.
      tot_cnt++; if ({fa_x, fa_y, fa_cin} !== 3'b010) $display("FAIL run_bit0_fa got=%b exp=010", {fa_x, fa_y, fa_cin}); else pass_cnt++;
      @(negedge clk);
      a = 8'd50; b = 8'd50; sub = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done) dones++;
         @(negedge clk);
      end
      tot_cnt++; if (dones !== 1) $display("FAIL ignore_done_pulses got=%0d exp=1", dones); else pass_cnt++;
      tot_cnt++; if (result !== 8'd127) $display("FAIL ignore_result got=%0d exp=127", result); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL ignore_idle got=%b exp=0", busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] r; logic c, o; int lat;
      run_op(8'd10, 8'd20, 1'b0, r, c, o, lat);
      tot_cnt++; if (r !== 8'd30) $display("FAIL b2b_first got=%0d exp=30", r); else pass_cnt++;
      // run_op starts at the very next negedge: the first IDLE cycle after DONE.
      run_op(8'd3, 8'd4, 1'b0, r, c, o, lat);
      tot_cnt++; if (lat !== 8) $display("FAIL b2b_latency got=%0d exp=8", lat); else pass_cnt++;
      tot_cnt++; if (r !== 8'd7) $display("FAIL b2b_second got=%0d exp=7", r); else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      logic [7:0] r; logic c, o; int lat;
      @(negedge clk);
      a = 8'd200; b = 8'd100; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      tot_cnt++; if ({busy, done} !== 2'b00) $display("FAIL rst_mid_busy got=%b exp=00", {busy, done}); else pass_cnt++;
      tot_cnt++; if (result !== 8'd0) $display("FAIL rst_mid_result got=%0d exp=0", result); else pass_cnt++;
      tot_cnt++; if ({carry_out, overflow, fa_x, fa_y, fa_cin} !== 5'b0) $display("FAIL rst_mid_outs got=%b exp=00000", {carry_out, overflow, fa_x, fa_y, fa_cin}); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      run_op(8'd1, 8'd1, 1'b0, r, c, o, lat);
      tot_cnt++; if (lat !== 8) $display("FAIL rst_after_latency got=%0d exp=8", lat); else pass_cnt++;
      tot_cnt++; if (r !== 8'd2) $display("FAIL rst_after_result got=%0d exp=2", r); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
